prim_alert_rx_lane: RTL

PRIM_ALERT_RX_LANE -- requirements
Module: prim_alert_rx_lane

---
 rtl/prim_alert_rx_lane_if.sv | 9 +
 rtl/prim_alert_rx_lane.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/prim_alert_rx_lane_if.sv
// Alert lane differential wiring: sender drives alert_tx, receiver drives alert_rx.
// alert_tx = {alert_p, alert_n}; alert_rx = {ping_p, ping_n, ack_p, ack_n}.
interface prim_alert_rx_lane_if;
  logic [1:0] alert_tx;
  logic [3:0] alert_rx;

  modport master (output alert_tx, input alert_rx);
  modport slave  (input alert_tx, output alert_rx);
endinterface

// File: rtl/prim_alert_rx_lane.sv
// Alert receiver lane: decodes the sender's alert pair, acknowledges it, launches pings
// and supports in-band sender reinitialisation.
module prim_alert_rx_lane #(
  parameter bit AsyncOn = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] alert_tx_i,   // {alert_p, alert_n}
  output logic [3:0] alert_rx_o,   // {ping_p, ping_n, ack_p, ack_n}
  input  logic       ping_req_i,
  input  logic       init_trig_i,
  output logic       alert_o,
  output logic       ping_ok_o,
  output logic       integ_fail_o
);

  localparam int Stages = AsyncOn ? 2 : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StHsAck   = 2'd1;
  localparam logic [1:0] StPause   = 2'd2;
  localparam logic [1:0] StInitReq = 2'd3;

  logic [Stages:0] w_pipe_p;
  logic [Stages:0] w_pipe_n;

  assign w_pipe_p[0] = alert_tx_i[1];
  assign w_pipe_n[0] = alert_tx_i[0];

  // Each stage resets to the idle differential value so the decoder sees a clean pair.
  for (genvar gi = 0; gi < Stages; gi++) begin : g_sync
    logic r_p;
    logic r_n;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_p <= 1'b0;
        r_n <= 1'b1;
      end else begin
        r_p <= w_pipe_p[gi];
        r_n <= w_pipe_n[gi];
      end
    end
    assign w_pipe_p[gi+1] = r_p;
    assign w_pipe_n[gi+1] = r_n;
  end

  logic w_level;
  logic w_sigint;

  assign w_level      = w_pipe_p[Stages];
  assign w_sigint     = (w_pipe_p[Stages] == w_pipe_n[Stages]);
  assign integ_fail_o = w_sigint;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_ping_pending;
  logic       r_ping_p;
  logic       r_ping_n;
  logic       r_ack_p;
  logic       r_ack_n;
  logic       w_alert;
  logic       w_ping_ok;
  logic       w_ping_launch;

  always_comb begin
    w_state_next = r_state;
    w_alert      = 1'b0;
    w_ping_ok    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_sigint) begin
          w_state_next = StIdle;
        end else if (w_level) begin
          w_state_next = StHsAck;
          if (r_ping_pending) begin
            w_ping_ok = 1'b1;
          end else begin
            w_alert = 1'b1;
          end
        end
      end
      StHsAck: begin
        if (w_sigint) begin
          w_state_next = StIdle;
        end else if (!w_level) begin
          w_state_next = StPause;
        end
      end
      StPause: begin
        w_state_next = StIdle;
      end
      StInitReq: begin
        // Leave only once the sender presents a clean, deasserted pair.
        if (!init_trig_i && !w_sigint && !w_level) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    if (init_trig_i) begin
      w_state_next = StInitReq;
      w_alert      = 1'b0;
      w_ping_ok    = 1'b0;
    end
  end

  assign w_ping_launch = ping_req_i && !r_ping_pending && (r_state != StInitReq);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= StIdle;
      r_ping_pending <= 1'b0;
      r_ping_p       <= 1'b0;
      r_ping_n       <= 1'b1;
      r_ack_p        <= 1'b0;
      r_ack_n        <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == StInitReq) begin
        // Both pairs collapse to 00, which the sender reads as a reinit request.
        r_ping_pending <= 1'b0;
        r_ping_p       <= 1'b0;
        r_ping_n       <= 1'b0;
        r_ack_p        <= 1'b0;
        r_ack_n        <= 1'b0;
      end else begin
        if (r_state == StInitReq) begin
          r_ping_p <= 1'b0;
          r_ping_n <= 1'b1;
        end else if (w_ping_launch) begin
          r_ping_p <= ~r_ping_p;
          r_ping_n <= r_ping_p;
        end
        if (w_ping_launch) begin
          r_ping_pending <= 1'b1;
        end else if (w_ping_ok) begin
          r_ping_pending <= 1'b0;
        end
        r_ack_p <= (w_state_next == StHsAck);
        r_ack_n <= (w_state_next != StHsAck);
      end
    end
  end

  assign alert_rx_o = {r_ping_p, r_ping_n, r_ack_p, r_ack_n};
  assign alert_o    = w_alert;
  assign ping_ok_o  = w_ping_ok;

endmodule
